// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: shares the single-port inst ROM between IF and DBG, registered read data.
// Optional address checking is enabled by defining INST_ROM_ARB_BOUND_CHK_EN.
module inst_rom_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_DEPTH_LOG2 = 17,
    parameter int MAX_WAIT       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_inst,
    output logic              stallreq_if
);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    typedef enum logic [1:0] {IDLE, IF_RSP, DBG_RSP} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] word;
    logic dbg_force, bad, any_gnt;

    // Grants are gated by reset so every output drops the moment rst_n falls.
    assign dbg_force = dbg_req && (wait_cnt >= CW'(MAX_WAIT));
    assign dbg_gnt = rst_n & dbg_req & (~if_req | dbg_force);
    assign if_gnt = rst_n & if_req & ~dbg_gnt;
    assign any_gnt = if_gnt | dbg_gnt;
    assign stallreq_if = rst_n & if_req & ~if_gnt;
    assign gnt_addr = dbg_gnt ? dbg_addr : if_addr;
`ifdef INST_ROM_ARB_BOUND_CHK_EN
    assign bad = (|gnt_addr[1:0]) | (|(gnt_addr >> (MEM_DEPTH_LOG2 + 2)));
`else
    assign bad = 1'b0;
`endif
    assign mem_ce = any_gnt & ~bad;
    assign mem_addr = mem_ce ? gnt_addr : '0;
    assign word = bad ? '0 : mem_inst;
    assign if_rvalid = (state == IF_RSP);
    assign dbg_rvalid = (state == DBG_RSP);

    always_comb begin
        state_nxt = if_gnt ? IF_RSP : dbg_gnt ? DBG_RSP : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            if_rdata  <= '0;
            dbg_rdata <= '0;
            if_err    <= 1'b0;
            dbg_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (dbg_req && !dbg_gnt) ? wait_cnt + CW'(wait_cnt < CW'(MAX_WAIT)) : '0;
            if (if_gnt) begin
                if_rdata <= word;
                if_err   <= bad;
            end
            if (dbg_gnt) begin
                dbg_rdata <= word;
                dbg_err   <= bad;
            end
        end
    end
endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb_inst_rom_arbiter: table-driven per-cycle vectors with a read-response scoreboard.
module tb_inst_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, dbg_req = 1'b0;
    logic [31:0] if_addr = '0, dbg_addr = '0;
    logic        if_gnt, if_rvalid, if_err, dbg_gnt, dbg_rvalid, dbg_err, mem_ce, stallreq_if;
    logic [31:0] if_rdata, dbg_rdata, mem_addr, mem_inst;
    int checks = 0, failures = 0;

    typedef struct {
        logic ir; logic [31:0] ia; logic dr; logic [31:0] da;
        logic gi; logic gd; logic st; logic ce; logic [31:0] ma;
    } vec_t;
    vec_t vecs[$];
    logic [32:0] if_q[$], dbg_q[$];
    logic if_pend = 1'b0, dbg_pend = 1'b0;

    inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH_LOG2(17), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_inst(mem_inst), .stallreq_if(stallreq_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        logic [16:0] idx;
        idx = a[18:2];
        return (idx == 17'd2) ? 32'h3401_0020 : {16'hC0DE, idx[15:0]};
    endfunction

    // ROM output is garbage while disabled so a leaked disabled read shows up in rdata.
    assign mem_inst = mem_ce ? rom(mem_addr) : 32'hDEAD_BEEF;

    function automatic logic is_bad(input logic [31:0] a);
`ifdef INST_ROM_ARB_BOUND_CHK_EN
        return (a[1:0] != 2'b0) || ((a >> 19) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [32:0] exp_rsp(input logic [31:0] a);
        return is_bad(a) ? {1'b1, 32'h0} : {1'b0, rom(a)};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                       input logic gi, input logic gd, input logic st, input logic ce, input logic [31:0] ma);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.da = da;
        v.gi = gi; v.gd = gd; v.st = st; v.ce = ce; v.ma = ma;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        logic [32:0] r;
        if_req = v.ir; if_addr = v.ia; dbg_req = v.dr; dbg_addr = v.da;
        @(negedge clk);
        chk("if_gnt", {31'b0, if_gnt}, {31'b0, v.gi});
        chk("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, v.gd});
        chk("stallreq_if", {31'b0, stallreq_if}, {31'b0, v.st});
        chk("mem_ce", {31'b0, mem_ce}, {31'b0, v.ce});
        chk("mem_addr", mem_addr, v.ma);
        chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, if_pend});
        chk("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, dbg_pend});
        if (if_pend) begin
            r = if_q.pop_front();
            chk("if_rdata", if_rdata, r[31:0]);
            chk("if_err", {31'b0, if_err}, {31'b0, r[32]});
        end
        if (dbg_pend) begin
            r = dbg_q.pop_front();
            chk("dbg_rdata", dbg_rdata, r[31:0]);
            chk("dbg_err", {31'b0, dbg_err}, {31'b0, r[32]});
        end
        if_pend = v.gi;
        dbg_pend = v.gd;
        if (v.gi) if_q.push_back(exp_rsp(v.ia));
        if (v.gd) dbg_q.push_back(exp_rsp(v.da));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // IF only, ROM[2]
        repeat (3) add(1, 32'h8, 0, 0, 1, 0, 0, 1, 32'h8);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // contention: DBG forced after four refusals, then counter restarts
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) add(1, 32'h10, 1, 32'h20, 0, 1, 1, 1, 32'h20);
            else add(1, 32'h10, 1, 32'h20, 1, 0, 0, 1, 32'h10);
        end
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // back-to-back alternation
        add(1, 32'h4, 0, 0, 1, 0, 0, 1, 32'h4);
        add(0, 0, 1, 32'hC, 0, 1, 0, 1, 32'hC);
        add(1, 32'h0, 0, 0, 1, 0, 0, 1, 32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // DBG withdrawn after two refusals; wait count must restart from zero
        repeat (2) add(1, 32'h14, 1, 32'h18, 1, 0, 0, 1, 32'h14);
        add(1, 32'h14, 0, 0, 1, 0, 0, 1, 32'h14);
        repeat (4) add(1, 32'h14, 1, 32'h18, 1, 0, 0, 1, 32'h14);
        add(1, 32'h14, 1, 32'h18, 0, 1, 1, 1, 32'h18);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // misaligned and out-of-range accesses
`ifdef INST_ROM_ARB_BOUND_CHK_EN
        add(0, 0, 1, 32'h6, 0, 1, 0, 0, 32'h0);
        add(0, 0, 1, 32'h8_0000, 0, 1, 0, 0, 32'h0);
        add(1, 32'h8_0000, 0, 0, 1, 0, 0, 0, 32'h0);
`else
        add(0, 0, 1, 32'h6, 0, 1, 0, 1, 32'h6);
        add(0, 0, 1, 32'h8_0000, 0, 1, 0, 1, 32'h8_0000);
        add(1, 32'h8_0000, 0, 0, 1, 0, 0, 1, 32'h8_0000);
`endif
        add(0, 0, 1, 32'h8, 0, 1, 0, 1, 32'h8);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);

        #1;
        chk("rst if_gnt", {31'b0, if_gnt}, 32'h0);
        chk("rst if_rvalid", {31'b0, if_rvalid}, 32'h0);
        chk("rst mem_ce", {31'b0, mem_ce}, 32'h0);
        chk("rst if_rdata", if_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        foreach (vecs[i]) apply(vecs[i]);

        // reset asserted while an IF response is being presented
        begin
            vec_t v;
            v.ir = 1; v.ia = 32'h8; v.dr = 0; v.da = 0;
            v.gi = 1; v.gd = 0; v.st = 0; v.ce = 1; v.ma = 32'h8;
            apply(v);
        end
        chk("pre-rst if_rvalid", {31'b0, if_rvalid}, 32'h1);
        dbg_req = 1'b1; dbg_addr = 32'hC;
        rst_n = 1'b0;
        #1;
        chk("async if_rvalid", {31'b0, if_rvalid}, 32'h0);
        chk("async if_rdata", if_rdata, 32'h0);
        chk("async if_gnt", {31'b0, if_gnt}, 32'h0);
        chk("async dbg_gnt", {31'b0, dbg_gnt}, 32'h0);
        chk("async stallreq_if", {31'b0, stallreq_if}, 32'h0);
        chk("async mem_ce", {31'b0, mem_ce}, 32'h0);
        chk("async mem_addr", mem_addr, 32'h0);
        if_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post-rst if_rvalid", {31'b0, if_rvalid}, 32'h0);
            chk("post-rst dbg_rvalid", {31'b0, dbg_rvalid}, 32'h0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
